// File: rtl/music_sequencer_pkg.sv
// Shared types and constants for the score-playback sequencer.
// A score entry is {rest, dur, freq}; dur==0 marks the end of the score.
package music_pkg;

    localparam int DUR_W  = 4;
    localparam int FREQ_W = 16;
    localparam int NOTE_W = 1 + DUR_W + FREQ_W;

    localparam logic [DUR_W-1:0] END_DUR = 4'd0;

    localparam logic [FREQ_W-1:0] G4  = 16'd4208;
    localparam logic [FREQ_W-1:0] DS4 = 16'd3339;
    localparam logic [FREQ_W-1:0] AS4 = 16'd5005;

    typedef struct packed {
        logic              rest;
        logic [DUR_W-1:0]  dur;
        logic [FREQ_W-1:0] freq;
    } note_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_PLAY  = 3'd3,
        S_DONE  = 3'd4
    } seq_state_t;

    function automatic logic is_end(input note_t n);
        return (n.dur == END_DUR);
    endfunction

endpackage

// File: rtl/music_sequencer_score_ram.sv
// Score storage: one write port, one synchronous read port with 1-cycle latency.
// A read of the address being written returns the old contents.
module score_ram
    import music_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  note_t         wr_data,
    input  logic [AW-1:0] rd_addr,
    output note_t         rd_data
);

    note_t mem_r [DEPTH];

    // Write port and registered read port (read-before-write, contents not reset)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
        rd_data <= mem_r[rd_addr];
    end

endmodule

// File: rtl/music_sequencer.sv
// Score-playback controller: walks the score RAM at tempo-step granularity and
// drives one audio channel's en/freq/gen_sel/volume inputs from registered outputs.
module music_sequencer
    import music_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH),
    parameter int TICK_DIV = 3125000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              loop_i,
    input  logic [2:0]        gen_sel_i,
    input  logic [7:0]        volume_i,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [NOTE_W-1:0] wr_data_i,
    output logic              ch_en_o,
    output logic [2:0]        ch_gen_sel_o,
    output logic [FREQ_W-1:0] ch_freq_o,
    output logic [7:0]        ch_volume_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [AW-1:0]     step_o
);

    localparam int TW = $clog2(TICK_DIV);

    seq_state_t        state_r;
    seq_state_t        state_nxt_s;
    logic [AW-1:0]     addr_r;
    logic [AW-1:0]     addr_nxt_s;
    logic [TW-1:0]     tick_r;
    logic [TW-1:0]     tick_nxt_s;
    logic [DUR_W-1:0]  dur_r;
    logic [DUR_W-1:0]  dur_nxt_s;

    logic              en_case_s;
    logic              en_nxt_s;
    logic              busy_nxt_s;
    logic              done_nxt_s;
    logic [2:0]        gen_nxt_s;
    logic [7:0]        vol_nxt_s;
    logic [FREQ_W-1:0] freq_nxt_s;
    logic [AW-1:0]     step_nxt_s;

    note_t             rd_note_s;
    note_t             wr_note_s;
    logic              wr_accept_s;
    logic              start_ok_s;
    logic              abort_s;
    logic              tick_wrap_s;
    logic              dur_last_s;
    logic              addr_last_s;

    assign wr_note_s   = wr_data_i;
    assign wr_accept_s = wr_en_i & ~busy_o;
    assign start_ok_s  = start_i & ~stop_i;
    assign abort_s     = stop_i & (state_r != S_IDLE);
    assign tick_wrap_s = (tick_r == TW'(TICK_DIV - 1));
    assign dur_last_s  = (dur_r == DUR_W'(1));
    assign addr_last_s = (addr_r == AW'(DEPTH - 1));

    score_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_score_ram (
        .clk     (clk),
        .wr_en   (wr_accept_s),
        .wr_addr (wr_addr_i),
        .wr_data (wr_note_s),
        .rd_addr (addr_r),
        .rd_data (rd_note_s)
    );

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; stop aborts from any active state
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_ok_s) state_nxt_s = S_FETCH;
                else            state_nxt_s = S_IDLE;
            end
            S_FETCH: begin
                if (stop_i) state_nxt_s = S_IDLE;
                else        state_nxt_s = S_LOAD;
            end
            S_LOAD: begin
                if (stop_i)                  state_nxt_s = S_IDLE;
                else if (is_end(rd_note_s))  state_nxt_s = loop_i ? S_FETCH : S_DONE;
                else                         state_nxt_s = S_PLAY;
            end
            S_PLAY: begin
                if (stop_i)                          state_nxt_s = S_IDLE;
                else if (tick_wrap_s && dur_last_s) begin
                    if (addr_last_s) state_nxt_s = loop_i ? S_FETCH : S_DONE;
                    else             state_nxt_s = S_FETCH;
                end else begin
                    state_nxt_s = S_PLAY;
                end
            end
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Next values of counters and channel outputs
    always_comb begin
        addr_nxt_s = addr_r;
        tick_nxt_s = tick_r;
        dur_nxt_s  = dur_r;
        en_case_s  = ch_en_o;
        freq_nxt_s = ch_freq_o;
        gen_nxt_s  = ch_gen_sel_o;
        vol_nxt_s  = ch_volume_o;
        step_nxt_s = step_o;
        if (abort_s) begin
            en_case_s = 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start_ok_s) begin
                        gen_nxt_s  = gen_sel_i;
                        vol_nxt_s  = volume_i;
                        addr_nxt_s = {AW{1'b0}};
                    end else begin
                        addr_nxt_s = addr_r;
                    end
                end
                S_LOAD: begin
                    if (is_end(rd_note_s)) begin
                        if (loop_i) addr_nxt_s = {AW{1'b0}};
                        else        addr_nxt_s = addr_r;
                    end else begin
                        step_nxt_s = addr_r;
                        en_case_s  = ~rd_note_s.rest;
                        dur_nxt_s  = rd_note_s.dur;
                        tick_nxt_s = {TW{1'b0}};
                        if (!rd_note_s.rest) freq_nxt_s = rd_note_s.freq;
                        else                 freq_nxt_s = ch_freq_o;
                    end
                end
                S_PLAY: begin
                    if (tick_wrap_s) begin
                        tick_nxt_s = {TW{1'b0}};
                        dur_nxt_s  = dur_r - DUR_W'(1);
                        // DEPTH is a power of two, so the last address wraps to 0
                        if (dur_last_s) addr_nxt_s = addr_r + AW'(1);
                        else            addr_nxt_s = addr_r;
                    end else begin
                        tick_nxt_s = tick_r + TW'(1);
                    end
                end
                S_FETCH: addr_nxt_s = addr_r;
                S_DONE:  addr_nxt_s = addr_r;
                default: addr_nxt_s = addr_r;
            endcase
        end
        en_nxt_s   = (state_nxt_s == S_DONE) ? 1'b0 : en_case_s;
        done_nxt_s = (state_nxt_s == S_DONE);
        busy_nxt_s = (state_nxt_s != S_IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_r       <= {AW{1'b0}};
            tick_r       <= {TW{1'b0}};
            dur_r        <= {DUR_W{1'b0}};
            ch_en_o      <= 1'b0;
            ch_gen_sel_o <= 3'd0;
            ch_freq_o    <= {FREQ_W{1'b0}};
            ch_volume_o  <= 8'd0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            step_o       <= {AW{1'b0}};
        end else begin
            addr_r       <= addr_nxt_s;
            tick_r       <= tick_nxt_s;
            dur_r        <= dur_nxt_s;
            ch_en_o      <= en_nxt_s;
            ch_gen_sel_o <= gen_nxt_s;
            ch_freq_o    <= freq_nxt_s;
            ch_volume_o  <= vol_nxt_s;
            busy_o       <= busy_nxt_s;
            done_o       <= done_nxt_s;
            step_o       <= step_nxt_s;
        end
    end

endmodule

// File: tb/tb_music_sequencer.sv
// Scoreboard bench: every change of the DUT's output snapshot is matched against a
// queued expected snapshot, and the cycle count each snapshot was held is checked.
module tb_music_sequencer;
    import music_pkg::*;

    localparam int AW = 5;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start_i = 1'b0;
    logic              stop_i = 1'b0;
    logic              loop_i = 1'b0;
    logic [2:0]        gen_sel_i = 3'd0;
    logic [7:0]        volume_i = 8'd0;
    logic              wr_en_i = 1'b0;
    logic [AW-1:0]     wr_addr_i = '0;
    logic [NOTE_W-1:0] wr_data_i = '0;
    logic              ch_en_o;
    logic [2:0]        ch_gen_sel_o;
    logic [FREQ_W-1:0] ch_freq_o;
    logic [7:0]        ch_volume_o;
    logic              busy_o;
    logic              done_o;
    logic [AW-1:0]     step_o;

    music_sequencer #(.DEPTH(32), .AW(AW), .TICK_DIV(8)) dut (
        .clk(clk), .rstn(rstn), .start_i(start_i), .stop_i(stop_i), .loop_i(loop_i),
        .gen_sel_i(gen_sel_i), .volume_i(volume_i), .wr_en_i(wr_en_i),
        .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .ch_en_o(ch_en_o),
        .ch_gen_sel_o(ch_gen_sel_o), .ch_freq_o(ch_freq_o), .ch_volume_o(ch_volume_o),
        .busy_o(busy_o), .done_o(done_o), .step_o(step_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          busy;
        logic          en;
        logic          done;
        logic [AW-1:0] step;
        logic [15:0]   freq;
        logic [2:0]    gen;
        logic [7:0]    vol;
    } snap_t;

    typedef struct {
        snap_t s;
        int    len;
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         bad = 0;
    logic       mon_en = 1'b0;
    logic [2:0] exp_gen = 3'd0;
    logic [7:0] exp_vol = 8'd0;

    // len = expected cycles this snapshot is held (0 = not checked)
    function automatic void push(input logic busy, input logic en, input logic done,
                                 input int step, input logic [15:0] f, input int len);
        exp_t e;
        e.s   = {busy, en, done, AW'(step), f, exp_gen, exp_vol};
        e.len = len;
        q.push_back(e);
    endfunction

    function automatic void push_full_score();
        push(1'b1, 1'b0, 1'b0, 0, 16'd0, 2);
        for (int k = 0; k < 31; k++) push(1'b1, 1'b1, 1'b0, k, G4, 10);
        push(1'b1, 1'b1, 1'b0, 31, G4, 8);
        push(1'b1, 1'b0, 1'b1, 31, G4, 1);
        push(1'b0, 1'b0, 1'b0, 31, G4, 0);
    endfunction

    // Monitor: compare on every change of the output snapshot
    initial begin
        snap_t cur;
        snap_t prev;
        exp_t  e;
        int    run;
        int    len_exp;
        prev = '0;
        run = 0;
        len_exp = 0;
        forever begin
            @(negedge clk);
            cur = {busy_o, ch_en_o, done_o, step_o, ch_freq_o, ch_gen_sel_o, ch_volume_o};
            if (!mon_en) begin
                prev = cur;
                run = 0;
                len_exp = 0;
            end else if (cur != prev) begin
                if (len_exp != 0) begin
                    total++;
                    if (run != len_exp) begin
                        bad++;
                        $display("FAIL hold_len: got %0d cycles, want %0d (snap %h)", run, len_exp, prev);
                    end
                end
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_change: got %h, want no change", cur);
                    len_exp = 0;
                end else begin
                    e = q.pop_front();
                    total++;
                    if (cur !== e.s) begin
                        bad++;
                        $display("FAIL snapshot: got %h, want %h", cur, e.s);
                    end
                    len_exp = e.len;
                end
                prev = cur;
                run = 1;
            end else begin
                run++;
            end
        end
    end

    task automatic wr(input int a, input logic rest, input logic [3:0] dur, input logic [15:0] f);
        @(negedge clk);
        wr_en_i = 1'b1;
        wr_addr_i = AW'(a);
        wr_data_i = {rest, dur, f};
        @(negedge clk);
        wr_en_i = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rstn = 1'b0;
        exp_gen = 3'd0;
        exp_vol = 8'd0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d, want 0", q.size());
            q.delete();
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: basic score with a rest
        do_reset();
        wr(0, 1'b0, 4'd2, G4);
        wr(1, 1'b1, 4'd1, 16'd0);
        wr(2, 1'b0, 4'd0, 16'd0);
        loop_i = 1'b0; gen_sel_i = 3'd5; volume_i = 8'h3C;
        exp_gen = 3'd5; exp_vol = 8'h3C;
        push(1'b1, 1'b0, 1'b0, 0, 16'd0, 2);
        push(1'b1, 1'b1, 1'b0, 0, G4, 18);
        push(1'b1, 1'b0, 1'b0, 1, G4, 10);
        push(1'b1, 1'b0, 1'b1, 1, G4, 1);
        push(1'b0, 1'b0, 1'b0, 1, G4, 0);
        pulse_start();
        wait_drain(200);

        // 2: motif looping twice, then loop dropped mid second pass
        do_reset();
        wr(0, 1'b0, 4'd1, DS4);
        wr(1, 1'b0, 4'd1, AS4);
        wr(2, 1'b0, 4'd2, G4);
        wr(3, 1'b0, 4'd0, 16'd0);
        loop_i = 1'b1; gen_sel_i = 3'd2; volume_i = 8'h80;
        exp_gen = 3'd2; exp_vol = 8'h80;
        push(1'b1, 1'b0, 1'b0, 0, 16'd0, 2);
        push(1'b1, 1'b1, 1'b0, 0, DS4, 10);
        push(1'b1, 1'b1, 1'b0, 1, AS4, 10);
        push(1'b1, 1'b1, 1'b0, 2, G4, 20);
        push(1'b1, 1'b1, 1'b0, 0, DS4, 10);
        push(1'b1, 1'b1, 1'b0, 1, AS4, 10);
        push(1'b1, 1'b1, 1'b0, 2, G4, 18);
        push(1'b1, 1'b0, 1'b1, 2, G4, 1);
        push(1'b0, 1'b0, 1'b0, 2, G4, 0);
        pulse_start();
        repeat (55) @(negedge clk);
        loop_i = 1'b0;
        wait_drain(400);

        // 3: stop at tick 3 of the second note, then restart from step 0
        do_reset();
        wr(0, 1'b0, 4'd1, DS4);
        wr(1, 1'b0, 4'd2, G4);
        wr(2, 1'b0, 4'd0, 16'd0);
        gen_sel_i = 3'd1; volume_i = 8'h55;
        exp_gen = 3'd1; exp_vol = 8'h55;
        push(1'b1, 1'b0, 1'b0, 0, 16'd0, 2);
        push(1'b1, 1'b1, 1'b0, 0, DS4, 10);
        push(1'b1, 1'b1, 1'b0, 1, G4, 4);
        push(1'b0, 1'b0, 1'b0, 1, G4, 0);
        pulse_start();
        repeat (15) @(negedge clk);
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
        wait_drain(100);
        push(1'b1, 1'b0, 1'b0, 1, G4, 2);
        push(1'b1, 1'b1, 1'b0, 0, DS4, 10);
        push(1'b1, 1'b1, 1'b0, 1, G4, 18);
        push(1'b1, 1'b0, 1'b1, 1, G4, 1);
        push(1'b0, 1'b0, 1'b0, 1, G4, 0);
        pulse_start();
        wait_drain(200);

        // 4: write, start and new gen/vol while busy are all ignored
        do_reset();
        wr(0, 1'b0, 4'd1, DS4);
        wr(1, 1'b0, 4'd1, G4);
        wr(2, 1'b0, 4'd0, 16'd0);
        gen_sel_i = 3'd7; volume_i = 8'hFF;
        exp_gen = 3'd7; exp_vol = 8'hFF;
        push(1'b1, 1'b0, 1'b0, 0, 16'd0, 2);
        push(1'b1, 1'b1, 1'b0, 0, DS4, 10);
        push(1'b1, 1'b1, 1'b0, 1, G4, 10);
        push(1'b1, 1'b0, 1'b1, 1, G4, 1);
        push(1'b0, 1'b0, 1'b0, 1, G4, 0);
        pulse_start();
        repeat (3) @(negedge clk);
        wr_en_i = 1'b1; wr_addr_i = AW'(1); wr_data_i = {1'b0, 4'd1, AS4};
        gen_sel_i = 3'd3; volume_i = 8'h11; start_i = 1'b1;
        @(negedge clk);
        wr_en_i = 1'b0; start_i = 1'b0;
        wait_drain(200);
        // start together with stop in IDLE: stop wins, no change expected
        @(negedge clk);
        start_i = 1'b1; stop_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; stop_i = 1'b0;
        repeat (10) @(negedge clk);

        // 5: full 32-entry score without end marker
        do_reset();
        for (int i = 0; i < 32; i++) wr(i, 1'b0, 4'd1, G4);
        loop_i = 1'b0; gen_sel_i = 3'd4; volume_i = 8'h40;
        exp_gen = 3'd4; exp_vol = 8'h40;
        push_full_score();
        pulse_start();
        wait_drain(500);

        // 6: asynchronous reset during PLAY, then replay of the retained score
        gen_sel_i = 3'd6; volume_i = 8'h99;
        exp_gen = 3'd6; exp_vol = 8'h99;
        push(1'b1, 1'b0, 1'b0, 31, G4, 2);
        push(1'b1, 1'b1, 1'b0, 0, G4, 0);
        pulse_start();
        repeat (5) @(negedge clk);
        chk("pre_reset_queue", 32'(q.size()), 32'd0);
        #3;
        mon_en = 1'b0;
        rstn = 1'b0;
        #1;
        chk("rst_en", 32'(ch_en_o), 32'd0);
        chk("rst_freq", 32'(ch_freq_o), 32'd0);
        chk("rst_gen", 32'(ch_gen_sel_o), 32'd0);
        chk("rst_vol", 32'(ch_volume_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_step", 32'(step_o), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        push_full_score();
        pulse_start();
        wait_drain(500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
